// File: rtl/axi_pkg.sv
// Shared AXI burst-type and response codes, plus FSM state types.
// Package only; no ports.
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Beat address generator for one AXI burst direction.
// load_i latches a burst, adv_i steps one beat; idx_o/err_o describe
// the beat that will be current after this edge; last_o marks the final beat.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic                     adv_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [7:0]               len_i,
  input  logic [2:0]               size_i,
  input  logic [1:0]               burst_i,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     err_o,
  output logic                     last_o
);
  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] step, wrap_m, nxt;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;

  function automatic logic beat_err(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        l,
    input logic [2:0]        s,
    input logic [1:0]        b
  );
    logic wrap_bad;
    wrap_bad = (b == BURST_WRAP) &&
               !(l inside {8'd1, 8'd3, 8'd7, 8'd15});
    return ((a >> (IDX_W + OFF_W)) != '0) ||
           (s > 3'(OFF_W)) || wrap_bad ||
           (b == BURST_RSVD);
  endfunction

  always_comb begin
    step   = ADDR_W'(1) << size_q;
    wrap_m = ((ADDR_W'(len_q) + ADDR_W'(1))
              << size_q) - ADDR_W'(1);
    unique case (burst_q)
      BURST_FIXED: nxt = addr_q;
      BURST_INCR:
        nxt = (addr_q & ~(step - 1)) + step;
      // stay inside the len+1 beat window
      BURST_WRAP:
        nxt = (addr_q & ~wrap_m) |
              (((addr_q & ~(step - 1)) + step)
               & wrap_m);
      default: nxt = addr_q;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      addr_d  = addr_i;
      len_d   = len_i;
      size_d  = size_i;
      burst_d = burst_i;
      cnt_d   = 8'd0;
    end else if (adv_i) begin
      addr_d = nxt;
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx_o  = addr_d[IDX_W+OFF_W-1:OFF_W];
  assign err_o  = beat_err(addr_d, len_d,
                           size_d, burst_d);
  assign last_o = (cnt_q == len_q);
endmodule

// File: rtl/axi_burst_sram.sv
// AXI burst slave on a dual-port word array; independent read/write FSMs.
// Ports: clock/reset, AR/R read channels, AW/W/B write channels.
module axi_burst_sram
  import axi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_ar_valid,
  output logic                io_ar_ready,
  input  logic [ADDR_W-1:0]   io_ar_addr,
  input  logic [7:0]          io_ar_len,
  input  logic [2:0]          io_ar_size,
  input  logic [1:0]          io_ar_burst,
  output logic                io_r_valid,
  input  logic                io_r_ready,
  output logic [DATA_W-1:0]   io_r_data,
  output logic [1:0]          io_r_resp,
  output logic                io_r_last,
  input  logic                io_aw_valid,
  output logic                io_aw_ready,
  input  logic [ADDR_W-1:0]   io_aw_addr,
  input  logic [7:0]          io_aw_len,
  input  logic [2:0]          io_aw_size,
  input  logic [1:0]          io_aw_burst,
  input  logic                io_w_valid,
  output logic                io_w_ready,
  input  logic [DATA_W-1:0]   io_w_data,
  input  logic [DATA_W/8-1:0] io_w_strb,
  output logic                io_b_valid,
  input  logic                io_b_ready,
  output logic [1:0]          io_b_resp
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  rd_state_e rs_q, rs_d;
  wr_state_e ws_q, ws_d;

  logic ar_hs, r_hs, r_adv, r_fetch;
  logic aw_hs, w_hs, w_adv, b_hs;
  logic [IDX_W-1:0] ridx, widx, widx_q;
  logic rerr, rerr_q, rlast;
  logic werr, werr_q, wlast, berr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign ar_hs   = io_ar_valid && (rs_q == R_IDLE);
  assign r_hs    = io_r_ready && (rs_q == R_DATA);
  assign r_adv   = r_hs && !rlast;
  assign r_fetch = ar_hs || r_adv;
  assign aw_hs   = io_aw_valid && (ws_q == W_IDLE);
  assign w_hs    = io_w_valid && (ws_q == W_DATA);
  assign w_adv   = w_hs && !wlast;
  assign b_hs    = io_b_ready && (ws_q == W_RESP);

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) u_rd_gen (
    .clk_i(clock), .rst_i(reset),
    .load_i(ar_hs), .adv_i(r_adv),
    .addr_i(io_ar_addr), .len_i(io_ar_len),
    .size_i(io_ar_size), .burst_i(io_ar_burst),
    .idx_o(ridx), .err_o(rerr), .last_o(rlast)
  );

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) u_wr_gen (
    .clk_i(clock), .rst_i(reset),
    .load_i(aw_hs), .adv_i(w_adv),
    .addr_i(io_aw_addr), .len_i(io_aw_len),
    .size_i(io_aw_size), .burst_i(io_aw_burst),
    .idx_o(widx), .err_o(werr), .last_o(wlast)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_q <= R_IDLE;
      ws_q <= W_IDLE;
    end else begin
      rs_q <= rs_d;
      ws_q <= ws_d;
    end
  end

  always_comb begin
    rs_d = rs_q;
    unique case (rs_q)
      R_IDLE:  if (ar_hs) rs_d = R_DATA;
      R_DATA:  if (r_hs && rlast) rs_d = R_IDLE;
      default: rs_d = R_IDLE;
    endcase
    ws_d = ws_q;
    unique case (ws_q)
      W_IDLE:  if (aw_hs) ws_d = W_DATA;
      W_DATA:  if (w_hs && wlast) ws_d = W_RESP;
      W_RESP:  if (b_hs) ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end

  always_comb begin
    io_ar_ready = (rs_q == R_IDLE);
    io_r_valid  = (rs_q == R_DATA);
    io_r_last   = io_r_valid && rlast;
    io_r_data   = rdata_q;
    io_r_resp   = rerr_q ? RESP_SLVERR : RESP_OKAY;
    io_aw_ready = (ws_q == W_IDLE);
    io_w_ready  = (ws_q == W_DATA);
    io_b_valid  = (ws_q == W_RESP);
    io_b_resp   = (io_b_valid && berr_q)
                  ? RESP_SLVERR : RESP_OKAY;
  end

  // Registered read port: a same-edge write is not yet visible,
  // and the beat stays put while the master stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else if (r_fetch) begin
      rdata_q <= rerr ? '0 : mem_q[ridx];
      rerr_q  <= rerr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      widx_q <= '0;
      werr_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      if (aw_hs || w_adv) begin
        widx_q <= widx;
        werr_q <= werr;
      end
      if (aw_hs) berr_q <= 1'b0;
      else if (w_hs) berr_q <= berr_q | werr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs && !werr_q) begin
      for (int b = 0; b < NB; b++) begin
        if (io_w_strb[b])
          mem_q[widx_q][8*b +: 8] <= io_w_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_burst_sram.sv
// Directed plus randomized bench for axi_burst_sram (64-bit, 1024 words).
// A byte-level burst model predicts every beat, response and last flag.
module tb_axi_burst_sram;
  localparam int DW  = 64;
  localparam int AW  = 64;
  localparam int DEP = 1024;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          io_ar_valid = 1'b0;
  logic          io_ar_ready;
  logic [AW-1:0] io_ar_addr = '0;
  logic [7:0]    io_ar_len = '0;
  logic [2:0]    io_ar_size = '0;
  logic [1:0]    io_ar_burst = '0;
  logic          io_r_valid;
  logic          io_r_ready = 1'b0;
  logic [DW-1:0] io_r_data;
  logic [1:0]    io_r_resp;
  logic          io_r_last;
  logic          io_aw_valid = 1'b0;
  logic          io_aw_ready;
  logic [AW-1:0] io_aw_addr = '0;
  logic [7:0]    io_aw_len = '0;
  logic [2:0]    io_aw_size = '0;
  logic [1:0]    io_aw_burst = '0;
  logic          io_w_valid = 1'b0;
  logic          io_w_ready;
  logic [DW-1:0] io_w_data = '0;
  logic [7:0]    io_w_strb = '0;
  logic          io_b_valid;
  logic          io_b_ready = 1'b0;
  logic [1:0]    io_b_resp;

  always #5 clock = ~clock;

  axi_burst_sram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .clock(clock), .reset(reset),
    .io_ar_valid(io_ar_valid), .io_ar_ready(io_ar_ready),
    .io_ar_addr(io_ar_addr), .io_ar_len(io_ar_len),
    .io_ar_size(io_ar_size), .io_ar_burst(io_ar_burst),
    .io_r_valid(io_r_valid), .io_r_ready(io_r_ready),
    .io_r_data(io_r_data), .io_r_resp(io_r_resp),
    .io_r_last(io_r_last),
    .io_aw_valid(io_aw_valid), .io_aw_ready(io_aw_ready),
    .io_aw_addr(io_aw_addr), .io_aw_len(io_aw_len),
    .io_aw_size(io_aw_size), .io_aw_burst(io_aw_burst),
    .io_w_valid(io_w_valid), .io_w_ready(io_w_ready),
    .io_w_data(io_w_data), .io_w_strb(io_w_strb),
    .io_b_valid(io_b_valid), .io_b_ready(io_b_ready),
    .io_b_resp(io_b_resp)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] mdl [DEP];
  logic [63:0] dq [$];
  logic [7:0]  sq [$];
  logic [63:0] seen [$];
  logic [1:0]  seen_r [$];
  bit          rdy_q [$];
  bit          rnd_stall = 1'b0;
  logic [1:0]  last_b;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Address of beat i, straight from the burst definitions.
  function automatic logic [63:0] baddr(
    input logic [63:0] a, input int len,
    input int sz, input int bt, input int i);
    logic [63:0] nb, al, w, lo;
    nb = 64'd1 << sz;
    al = a / nb * nb;
    if (i == 0 || bt == 0 || bt == 3) return a;
    if (bt == 2) begin
      w  = 64'(len + 1) * nb;
      lo = a / w * w;
      return lo + (al - lo + 64'(i) * nb) % w;
    end
    return al + 64'(i) * nb;
  endfunction

  function automatic bit berr(
    input logic [63:0] ba, input int len,
    input int sz, input int bt);
    return (ba >= 64'(DEP * DW / 8)) || (sz > 3) ||
           (bt == 3) ||
           (bt == 2 && !(len == 1 || len == 3 ||
                         len == 7 || len == 15));
  endfunction

  function automatic bit next_rdy();
    if (rdy_q.size() > 0) return rdy_q.pop_front();
    if (rnd_stall) return ($urandom_range(0, 2) != 0);
    return 1'b1;
  endfunction

  task automatic put(input logic [63:0] d,
                     input logic [7:0] s);
    dq.push_back(d);
    sq.push_back(s);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_ar_ready"}, 64'(io_ar_ready), 64'd1);
    chk({t, "_aw_ready"}, 64'(io_aw_ready), 64'd1);
    chk({t, "_w_ready"},  64'(io_w_ready),  64'd0);
    chk({t, "_r_valid"},  64'(io_r_valid),  64'd0);
    chk({t, "_r_last"},   64'(io_r_last),   64'd0);
    chk({t, "_b_valid"},  64'(io_b_valid),  64'd0);
    chk({t, "_r_data"},   io_r_data,        64'd0);
    chk({t, "_r_resp"},   64'(io_r_resp),   64'd0);
    chk({t, "_b_resp"},   64'(io_b_resp),   64'd0);
  endtask

  task automatic ar_send(input logic [63:0] a,
                         input int len, input int sz,
                         input int bt);
    int n = 0;
    io_ar_valid = 1'b1;
    io_ar_addr  = a;
    io_ar_len   = 8'(len);
    io_ar_size  = 3'(sz);
    io_ar_burst = 2'(bt);
    while (!io_ar_ready && n < 20) begin
      step();
      n++;
    end
    chk("ar_ready", 64'(io_ar_ready), 64'd1);
    step();
    io_ar_valid = 1'b0;
  endtask

  task automatic aw_send(input logic [63:0] a,
                         input int len, input int sz,
                         input int bt);
    int n = 0;
    io_aw_valid = 1'b1;
    io_aw_addr  = a;
    io_aw_len   = 8'(len);
    io_aw_size  = 3'(sz);
    io_aw_burst = 2'(bt);
    while (!io_aw_ready && n < 20) begin
      step();
      n++;
    end
    chk("aw_ready", 64'(io_aw_ready), 64'd1);
    step();
    io_aw_valid = 1'b0;
  endtask

  task automatic wr_burst(input logic [63:0] a,
                          input int len, input int sz,
                          input int bt);
    logic [63:0] ba;
    bit e;
    bit any = 1'b0;
    int n;
    aw_send(a, len, sz, bt);
    for (int i = 0; i <= len; i++) begin
      ba = baddr(a, len, sz, bt, i);
      e  = berr(ba, len, sz, bt);
      io_w_valid = 1'b1;
      io_w_data  = dq[i];
      io_w_strb  = sq[i];
      n = 0;
      while (!io_w_ready && n < 20) begin
        step();
        n++;
      end
      chk("w_ready", 64'(io_w_ready), 64'd1);
      step();
      if (!e) begin
        for (int b = 0; b < 8; b++)
          if (sq[i][b])
            mdl[ba[12:3]][8*b +: 8] = dq[i][8*b +: 8];
      end
      any = any | e;
    end
    io_w_valid = 1'b0;
    io_b_ready = 1'b1;
    chk("b_valid", 64'(io_b_valid), 64'd1);
    chk("b_resp", 64'(io_b_resp),
        any ? 64'd2 : 64'd0);
    last_b = io_b_resp;
    step();
    io_b_ready = 1'b0;
    dq.delete();
    sq.delete();
  endtask

  task automatic rd_burst(input logic [63:0] a,
                          input int len, input int sz,
                          input int bt);
    logic [63:0] ba, ed, er;
    bit e, rdy;
    seen.delete();
    seen_r.delete();
    ar_send(a, len, sz, bt);
    for (int i = 0; i <= len; i++) begin
      ba = baddr(a, len, sz, bt, i);
      e  = berr(ba, len, sz, bt);
      ed = e ? 64'd0 : mdl[ba[12:3]];
      er = e ? 64'd2 : 64'd0;
      chk("r_valid", 64'(io_r_valid), 64'd1);
      chk("r_data", io_r_data, ed);
      chk("r_resp", 64'(io_r_resp), er);
      chk("r_last", 64'(io_r_last), 64'(i == len));
      seen.push_back(io_r_data);
      seen_r.push_back(io_r_resp);
      rdy = next_rdy();
      io_r_ready = rdy;
      while (!rdy) begin
        step();
        chk("hold_valid", 64'(io_r_valid), 64'd1);
        chk("hold_data", io_r_data, ed);
        chk("hold_resp", 64'(io_r_resp), er);
        rdy = next_rdy();
        io_r_ready = rdy;
      end
      step();
    end
    io_r_ready = 1'b0;
    chk("r_done", 64'(io_r_valid), 64'd0);
  endtask

  task automatic rnd_burst(output logic [63:0] a,
                           output int len, output int sz,
                           output int bt);
    int k;
    k  = int'($urandom_range(0, 9));
    bt = (k < 2) ? 0 : (k < 7) ? 1 : (k < 9) ? 2 : 3;
    sz = ($urandom_range(0, 9) == 0) ? 4
         : int'($urandom_range(0, 3));
    if (bt == 2 && $urandom_range(0, 7) != 0)
      len = (2 << $urandom_range(0, 3)) - 1;
    else
      len = int'($urandom_range(0, 15));
    a = 64'($urandom_range(0, 8191 + 256));
    if (bt == 2) a = a / (64'd1 << sz) * (64'd1 << sz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, old;
    int len, sz, bt;

    #1 reset = 1'b1;
    #1 chk_reset("por");
    @(posedge clock);
    #1 reset = 1'b0;

    // fill the array; also four full 256-beat bursts
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++)
        put({$urandom, $urandom}, 8'hFF);
      wr_burst(64'(k * 2048), 255, 3, 1);
    end
    rd_burst(64'h800, 255, 3, 1);
    chk("len255_beats", 64'(seen.size()), 64'd256);

    for (int i = 1; i <= 4; i++) put(64'(i), 8'hFF);
    wr_burst(64'h100, 3, 3, 1);
    chk("incr_bresp", 64'(last_b), 64'd0);
    rd_burst(64'h100, 3, 3, 1);
    for (int i = 0; i < 4; i++)
      chk("incr_rd", seen[i], 64'(i + 1));

    rd_burst(64'h110, 3, 3, 2);
    chk("wrap_0", seen[0], 64'd3);
    chk("wrap_1", seen[1], 64'd4);
    chk("wrap_2", seen[2], 64'd1);
    chk("wrap_3", seen[3], 64'd2);

    put(64'h1122334455667788, 8'hFF);
    wr_burst(64'h200, 0, 3, 1);
    put(64'hFFFFFFFFFFFFFFFF, 8'h0F);
    wr_burst(64'h200, 0, 3, 1);
    rd_burst(64'h200, 0, 3, 1);
    chk("strb_merge", seen[0], 64'h11223344FFFFFFFF);

    put(64'hCAFE0000BEEF0001, 8'hFF);
    put(64'hDEAD0000DEAD0002, 8'hFF);
    wr_burst(64'h1FF8, 1, 3, 1);
    chk("oor_bresp", 64'(last_b), 64'd2);
    rd_burst(64'h1FF8, 1, 3, 1);
    chk("oor_d0", seen[0], 64'hCAFE0000BEEF0001);
    chk("oor_r0", 64'(seen_r[0]), 64'd0);
    chk("oor_r1", 64'(seen_r[1]), 64'd2);
    chk("oor_d1", seen[1], 64'd0);

    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b1);
    rd_burst(64'h100, 3, 3, 1);
    for (int i = 0; i < 4; i++)
      chk("stall_rd", seen[i], 64'(i + 1));

    // read and write of one word on the same edge
    aw_send(64'h300, 0, 3, 1);
    old = mdl[96];
    io_w_valid  = 1'b1;
    io_w_data   = 64'hA5A5000012345678;
    io_w_strb   = 8'hFF;
    io_ar_valid = 1'b1;
    io_ar_addr  = 64'h300;
    io_ar_len   = 8'd0;
    io_ar_size  = 3'd3;
    io_ar_burst = 2'd1;
    chk("col_w_ready", 64'(io_w_ready), 64'd1);
    chk("col_ar_ready", 64'(io_ar_ready), 64'd1);
    step();
    io_w_valid  = 1'b0;
    io_ar_valid = 1'b0;
    mdl[96] = 64'hA5A5000012345678;
    chk("col_old", io_r_data, old);
    io_r_ready = 1'b1;
    io_b_ready = 1'b1;
    chk("col_b_valid", 64'(io_b_valid), 64'd1);
    chk("col_b_resp", 64'(io_b_resp), 64'd0);
    step();
    io_r_ready = 1'b0;
    io_b_ready = 1'b0;
    rd_burst(64'h300, 0, 3, 1);

    // reset in the middle of a write, with a read beat pending
    ar_send(64'h100, 3, 3, 1);
    aw_send(64'h380, 3, 3, 1);
    for (int i = 0; i < 2; i++) begin
      io_w_valid = 1'b1;
      io_w_data  = 64'h5500 + 64'(i);
      io_w_strb  = 8'hFF;
      chk("rst_w_ready", 64'(io_w_ready), 64'd1);
      step();
      mdl[112 + i] = 64'h5500 + 64'(i);
    end
    io_w_data = 64'h77777777;
    #2 reset = 1'b1;
    #1 chk_reset("rst_mid");
    @(posedge clock);
    #1;
    io_w_valid = 1'b0;
    reset = 1'b0;
    #1 chk_reset("rst_post");
    step();
    rd_burst(64'h380, 3, 3, 1);

    rnd_stall = 1'b1;
    for (int it = 0; it < 40; it++) begin
      rnd_burst(a, len, sz, bt);
      for (int i = 0; i <= len; i++)
        put({$urandom, $urandom}, 8'($urandom));
      wr_burst(a, len, sz, bt);
      rd_burst(a, len, sz, bt);
      rnd_burst(a, len, sz, bt);
      rd_burst(a, len, sz, bt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_burst_sram.md
AXI_BURST_SRAM -- requirements
Module: axi_burst_sram
Interface
REQ-001 SHALL have parameter DATA_W, default 64, data bus width in bits (64 or 128 only).
REQ-002 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of DATA_W-bit words in the internal array.
REQ-004 SHALL have clock  input  1  single clock; all logic is rising-edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have io_ar_valid  input  1  read address valid.
REQ-007 SHALL have io_ar_ready  output  1  read address ready.
REQ-008 SHALL have io_ar_addr  input  ADDR_W  read start byte address.
REQ-009 SHALL have io_ar_len  input  8  read beats minus one.
REQ-010 SHALL have io_ar_size  input  3  log2 of read beat bytes.
REQ-011 SHALL have io_ar_burst  input  2  read burst type: 0 FIXED, 1 INCR, 2 WRAP.
REQ-012 SHALL have io_r_valid  output  1  read data valid.
REQ-013 SHALL have io_r_ready  input  1  read data ready.
REQ-014 SHALL have io_r_data  output  DATA_W  read beat data, full bus word.
REQ-015 SHALL have io_r_resp  output  2  read beat response: 0 OKAY, 2 SLVERR.
REQ-016 SHALL have io_r_last  output  1  final read beat.
REQ-017 SHALL have io_aw_valid  input  1  write address valid.
REQ-018 SHALL have io_aw_ready  output  1  write address ready.
REQ-019 SHALL have io_aw_addr  input  ADDR_W  write start byte address.
REQ-020 SHALL have io_aw_len  input  8  write beats minus one.
REQ-021 SHALL have io_aw_size  input  3  log2 of write beat bytes.
REQ-022 SHALL have io_aw_burst  input  2  write burst type, same encoding as io_ar_burst.
REQ-023 SHALL have io_w_valid  input  1  write data valid.
REQ-024 SHALL have io_w_ready  output  1  write data ready.
REQ-025 SHALL have io_w_data  input  DATA_W  write beat data.
REQ-026 SHALL have io_w_strb  input  DATA_W/8  write byte enables.
REQ-027 SHALL have io_b_valid  output  1  write response valid.
REQ-028 SHALL have io_b_ready  input  1  write response ready.
REQ-029 SHALL have io_b_resp  output  2  write burst response: 0 OKAY, 2 SLVERR.
Function
REQ-030 SHALL run independent read FSM (R_IDLE, R_DATA) and write FSM (W_IDLE, W_DATA, W_RESP) concurrently on a dual-port array.
REQ-031 Read FSM: io_ar_ready=1 only in R_IDLE; AR handshake -> R_DATA; io_r_valid=1 in R_DATA; R_DATA -> R_IDLE on handshake with io_r_last=1.
REQ-032 Read latency: first beat valid the cycle after AR handshake; with io_r_ready held high, one beat per cycle; io_r_data/io_r_resp stable while io_r_valid && !io_r_ready.
REQ-033 Write FSM: io_aw_ready=1 only in W_IDLE; AW handshake -> W_DATA; io_w_ready=1 in W_DATA; each W handshake writes the bytes enabled by io_w_strb; handshake on beat len -> W_RESP; io_b_valid=1 in W_RESP; B handshake -> W_IDLE.
REQ-034 Beat address: FIXED keeps start address; INCR adds (1<<size) per beat, aligned down to size; WRAP wraps within a (len+1)<<size-byte aligned window.
REQ-035 Array word index SHALL be addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]; narrow beats return the full word, with lanes per the AXI rules.
REQ-036 SLVERR beat conditions: beat address >= DEPTH*DATA_W/8; size > log2(DATA_W/8); WRAP with len not in {1,3,7,15}; burst type 3.
REQ-037 An SLVERR read beat SHALL return data 0; an SLVERR write beat SHALL leave the array unchanged; io_b_resp is SLVERR if any beat of the burst erred.
REQ-038 A same-cycle read and write to one word SHALL return the old data on read.
REQ-039 A len=255 INCR burst SHALL complete with exactly 256 beats; beat counters are 8-bit and SHALL not wrap before the last beat.
Reset
REQ-040 Asserting reset at any time SHALL force R_IDLE/W_IDLE and clear the counters; outputs: io_ar_ready=1, io_aw_ready=1, io_w_ready=0, io_r_valid=0, io_r_last=0, io_b_valid=0, io_r_data=0, io_r_resp=0, io_b_resp=0.
REQ-041 Reset mid-burst SHALL abandon the burst; array contents are not cleared, and beats already written persist.
Structure
REQ-042 Burst-type and response-code constants SHALL live in shared package axi_pkg.
REQ-043 Beat-address generation SHALL be sub-module axi_burst_addr_gen, instantiated once per direction.
Verification (DATA_W=64, DEPTH=1024)
REQ-044 Setup: INCR write at 0x100, len=3, size=3, strb=0xFF, data 1..4; then read back. Required: b_resp=0; read returns 1,2,3,4 on consecutive cycles; r_last on beat 4.
REQ-045 Setup: 0x100 holds 1..4. Stimulus: WRAP read at 0x110, len=3, size=3. Required: data 3,4,1,2.
REQ-046 Setup: word 0x200 = 0x1122334455667788. Stimulus: write 0xFFFFFFFFFFFFFFFF with strb=0x0F. Required: readback 0x11223344FFFFFFFF.
REQ-047 Stimulus: INCR write at 0x1FF8, len=1 (second beat out of range). Required: beat 1 written, b_resp=2; then read same burst gives r_resp 0 then 2, with beat 2 data 0.
REQ-048 Stimulus: r_ready toggled 1,0,0,1 during a len=3 read, plus reset asserted mid-write. Required: data held while stalled; after reset, all outputs at reset values, ar_ready=aw_ready=1.
